// File: rtl/x_pulse_monitor_pkg.sv
// Shared definitions for the pulse monitor: FSM encoding and default sizes.
package x_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_WINDOW = 16;
  localparam int WIN_CNT_W  = 16;

endpackage

// File: rtl/x_pulse_monitor_if.sv
// Bundle of the monitor's request/result signals. The requester drives x and
// start; the monitor returns status, the synchronized x and the window results.
interface x_pulse_monitor_if
  import x_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             x;
  logic             start;
  logic             busy;
  logic             done;
  logic             x_sync;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] fall_cnt;
  logic [CNT_W-1:0] max_high;

  modport master (
    output x, start,
    input  busy, done, x_sync, rise_cnt, fall_cnt, max_high
  );

  modport slave (
    input  x, start,
    output busy, done, x_sync, rise_cnt, fall_cnt, max_high
  );

endinterface

// File: rtl/x_pulse_monitor_sync2.sv
// Two-flop synchronizer bringing the asynchronous x into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift d through two flops; reset clears both so x_sync restarts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/x_pulse_monitor.sv
// Measures edges and the longest high run of a synchronized signal over a
// fixed window of WINDOW cycles, started on request and reported with done.
module x_pulse_monitor
  import x_mon_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WINDOW = DEF_WINDOW
) (
  input logic              clk,
  input logic              rst,
  x_pulse_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [WIN_CNT_W-1:0] WIN_LAST = WIN_CNT_W'(WINDOW - 1);
  localparam logic [WIN_CNT_W-1:0] WIN_ONE  = WIN_CNT_W'(1);

  state_e               state_q;
  logic [WIN_CNT_W-1:0] winCnt_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 xSync;
  logic                 xPrev_q;

  logic [CNT_W-1:0]     riseCnt_q, riseCnt_d;
  logic [CNT_W-1:0]     fallCnt_q, fallCnt_d;
  logic [CNT_W-1:0]     runCnt_q,  runCnt_d;
  logic [CNT_W-1:0]     maxHigh_q, maxHigh_d;
  logic [CNT_W-1:0]     runInc;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (bus.x),
    .q   (xSync)
  );

  // Control FSM: window counter, registered busy/done; reset beats start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      winCnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q  <= MEASURE;
            winCnt_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        MEASURE: begin
          if (winCnt_q == WIN_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            winCnt_q <= winCnt_q + WIN_ONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Previous x_sync runs all the time so a first-cycle edge is still seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      xPrev_q <= 1'b0;
    end else begin
      xPrev_q <= xSync;
    end
  end

  assign runInc = (runCnt_q == CNT_MAX) ? CNT_MAX : runCnt_q + CNT_ONE;

  // Result next-state: clear on accepted start, update only while measuring.
  always_comb begin
    riseCnt_d = riseCnt_q;
    fallCnt_d = fallCnt_q;
    runCnt_d  = runCnt_q;
    maxHigh_d = maxHigh_q;
    if (state_q == IDLE && bus.start) begin
      riseCnt_d = '0;
      fallCnt_d = '0;
      runCnt_d  = '0;
      maxHigh_d = '0;
    end else if (state_q == MEASURE) begin
      if (xSync && !xPrev_q && riseCnt_q != CNT_MAX) begin
        riseCnt_d = riseCnt_q + CNT_ONE;
      end
      if (!xSync && xPrev_q && fallCnt_q != CNT_MAX) begin
        fallCnt_d = fallCnt_q + CNT_ONE;
      end
      if (xSync) begin
        runCnt_d = runInc;
        if (runInc > maxHigh_q) begin
          maxHigh_d = runInc;
        end
      end else begin
        runCnt_d = '0;
      end
    end
  end

  // Result registers; they hold between windows so done results stay valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      riseCnt_q <= '0;
      fallCnt_q <= '0;
      runCnt_q  <= '0;
      maxHigh_q <= '0;
    end else begin
      riseCnt_q <= riseCnt_d;
      fallCnt_q <= fallCnt_d;
      runCnt_q  <= runCnt_d;
      maxHigh_q <= maxHigh_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.x_sync   = xSync;
  assign bus.rise_cnt = riseCnt_q;
  assign bus.fall_cnt = fallCnt_q;
  assign bus.max_high = maxHigh_q;

endmodule

// File: doc/x_pulse_monitor.md
X_PULSE_MONITOR -- requirements
Module: x_pulse_monitor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have parameter CNT_W, default 8, width of all result counters.
REQ-003 The block SHALL have parameter WINDOW, default 16, number of measured cycles per run, range 1..65535.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 x  input  1  output of the upstream combinational stage, asynchronous to clk.
REQ-007 start  input  1  one-cycle request to begin a measurement window.
REQ-008 busy  output  1  high while a window is being measured.
REQ-009 done  output  1  one-cycle pulse marking that results are valid.
REQ-010 x_sync  output  1  x after two-flop synchronization.
REQ-011 rise_cnt  output  CNT_W  number of 0->1 transitions of x_sync in the last window.
REQ-012 fall_cnt  output  CNT_W  number of 1->0 transitions of x_sync in the last window.
REQ-013 max_high  output  CNT_W  longest run of consecutive x_sync=1 cycles in the last window.

Function
REQ-014 x_sync SHALL equal x delayed by exactly 2 clk cycles, independent of FSM state.
REQ-015 The FSM SHALL have states IDLE, MEASURE, DONE.
REQ-016 IDLE -> MEASURE when start=1 is sampled; rise_cnt, fall_cnt, max_high, run counter and window counter clear on that same edge.
REQ-017 MEASURE SHALL last exactly WINDOW cycles, then go to DONE; DONE SHALL last one cycle, then return to IDLE.
REQ-018 busy SHALL be 1 in MEASURE only; done SHALL be 1 in DONE only.
REQ-019 Edge detection SHALL compare x_sync with its value from the previous cycle; an edge counts only if the current cycle is in MEASURE.
REQ-020 The previous-value register SHALL run continuously, so an edge on the first MEASURE cycle is counted.
REQ-021 The run counter SHALL increment on each MEASURE cycle with x_sync=1 and clear on x_sync=0; max_high SHALL take max(max_high, run+1) whenever it increments.
REQ-022 If x_sync=1 on entry to MEASURE, the run SHALL start at the first MEASURE cycle and no rising edge SHALL be counted for it.
REQ-023 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 start in MEASURE or DONE SHALL be ignored; start in the cycle after DONE (IDLE) SHALL be accepted.
REQ-025 Results SHALL hold stable from DONE until the next accepted start.

Reset
REQ-026 rst=1 SHALL force IDLE, busy=0, done=0, all counters 0 and both synchronizer flops 0 on the next edge, including mid-MEASURE; no done pulse is produced for an aborted window.
REQ-027 rst SHALL take priority over start in the same cycle.

Structure
REQ-028 Package x_mon_pkg SHALL hold the state encoding (IDLE=2'd0, MEASURE=2'd1, DONE=2'd2) and the default CNT_W and WINDOW values.
REQ-029 The two-flop synchronizer SHALL be a separate sub-module named sync2 with ports clk, rst, d, q.
REQ-030 Window counter width SHALL be 16 bits; unused state encoding 2'd3 SHALL return to IDLE.

Verification (WINDOW=16, CNT_W=8)
REQ-031 x=0 constant, start at cycle 0 -> busy cycles 1..16, done at cycle 17, rise_cnt=0, fall_cnt=0, max_high=0.
REQ-032 x=1 held from before start -> rise_cnt=0, fall_cnt=0, max_high=16.
REQ-033 x toggles every clk cycle, x_sync already toggling at start -> rise_cnt=8, fall_cnt=8, max_high=1.
REQ-034 x high for 5 cycles, low for 3, high for 7, aligned so x_sync is 0 in the first MEASURE cycle -> rise_cnt=2, fall_cnt=1, max_high=7.
REQ-035 WINDOW=400, CNT_W=8, x=1 constant -> max_high=255 (saturated), no wrap.
REQ-036 rst pulsed at MEASURE cycle 8 -> no done pulse, all outputs 0; start 2 cycles later -> normal window, done 17 cycles after that start.
